// File: rtl/mio_ps2_tx.sv
// mio_ps2_tx: PS/2 host-to-device byte transmitter.
// Handles the clock inhibit, start bit, eight data bits LSB first, odd parity,
// stop, and the device acknowledge.
// Both line enables are open-drain controls and come straight from flops.
// Optional feature: define MIO_PS2_TX_TIMEOUT_EN to build a device-clock
// watchdog that aborts a stalled transfer.
//
// state   | meaning
// IDLE    | lines released, waiting for io_wrn
// INHIBIT | clock held low for INHIBIT_CYCLES
// START   | data pulled low (start bit) while the clock is still held
// SHIFT   | clock released; data, parity and stop are driven on device falling edges
// ACK     | waiting for the device acknowledge falling edge
// RECOVER | waiting for both lines high, then done
module mio_ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_wrn,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SHIFT,
    S_ACK,
    S_RECOVER
  } state_t;

  state_t        state, state_n;
  logic          clk_s1, clk_s2, clk_prev, data_s1, data_s2;
  logic          clk_fall;
  logic [IW-1:0] inh_cnt, inh_cnt_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    byte_q, byte_n;
  logic          parity_q, parity_n;
  logic          clk_oe_n, data_oe_n, done_n, ack_err_n;
  logic          cur_bit;

`ifdef MIO_PS2_TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          timeout_q, timeout_n;
`endif

  // Reject parameter values that would make the counters meaningless.
  if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("mio_ps2_tx: INHIBIT_CYCLES must be >= 1 and TIMEOUT_CYCLES >= 2");
  end

  // Two-flop synchronizers plus one history flop for clock edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {clk_s1, clk_s2, clk_prev, data_s1, data_s2} <= '1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data_in;
      data_s2  <= data_s1;
    end
  end

  assign clk_fall = clk_prev & ~clk_s2;

  // Bits 0..7 are data, 8 is parity, 9 is the stop bit (line released).
  assign cur_bit = (bit_cnt < 4'd8)  ? byte_q[bit_cnt[2:0]] :
                   (bit_cnt == 4'd8) ? parity_q : 1'b1;

  assign busy = (state != S_IDLE);

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_n   = state;
    inh_cnt_n = inh_cnt;
    bit_cnt_n = bit_cnt;
    byte_n    = byte_q;
    parity_n  = parity_q;
    clk_oe_n  = ps2_clk_oe;
    data_oe_n = ps2_data_oe;
    done_n    = 1'b0;
    ack_err_n = ack_err;
`ifdef MIO_PS2_TX_TIMEOUT_EN
    to_cnt_n  = to_cnt;
    timeout_n = timeout_q;
`endif
    case (state)
      S_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (!io_wrn) begin
          byte_n    = tx_data;
          parity_n  = ~^tx_data;
          ack_err_n = 1'b0;
`ifdef MIO_PS2_TX_TIMEOUT_EN
          timeout_n = 1'b0;
`endif
          inh_cnt_n = IW'(INHIBIT_CYCLES - 1);
          clk_oe_n  = 1'b1;
          state_n   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt == '0) begin
          data_oe_n = 1'b1;
          state_n   = S_START;
        end else begin
          inh_cnt_n = inh_cnt - IW'(1);
        end
      end
      S_START: begin
        clk_oe_n  = 1'b0;
        bit_cnt_n = 4'd0;
`ifdef MIO_PS2_TX_TIMEOUT_EN
        to_cnt_n  = TW'(TIMEOUT_CYCLES - 1);
`endif
        state_n   = S_SHIFT;
      end
      S_SHIFT, S_ACK: begin
        // done is only set here by a timeout abort; leave on the following cycle
        if (done) begin
          state_n = S_IDLE;
        end else if (clk_fall) begin
`ifdef MIO_PS2_TX_TIMEOUT_EN
          to_cnt_n = TW'(TIMEOUT_CYCLES - 1);
`endif
          if (state == S_ACK) begin
            ack_err_n = data_s2;
            state_n   = S_RECOVER;
          end else begin
            data_oe_n = ~cur_bit;
            if (bit_cnt == 4'd9) state_n = S_ACK;
            else bit_cnt_n = bit_cnt + 4'd1;
          end
        end
`ifdef MIO_PS2_TX_TIMEOUT_EN
        else if (to_cnt == '0) begin
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          timeout_n = 1'b1;
          done_n    = 1'b1;
        end else begin
          to_cnt_n = to_cnt - TW'(1);
        end
`endif
      end
      S_RECOVER: begin
        // done is raised while still busy, so a write in that cycle is ignored
        if (done) state_n = S_IDLE;
        else if (clk_s2 && data_s2) done_n = 1'b1;
      end
      default: begin
        state_n   = S_IDLE;
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      inh_cnt     <= '0;
      bit_cnt     <= '0;
      byte_q      <= '0;
      parity_q    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
    end else begin
      state       <= state_n;
      inh_cnt     <= inh_cnt_n;
      bit_cnt     <= bit_cnt_n;
      byte_q      <= byte_n;
      parity_q    <= parity_n;
      ps2_clk_oe  <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      done        <= done_n;
      ack_err     <= ack_err_n;
    end
  end

`ifdef MIO_PS2_TX_TIMEOUT_EN
  // Device-clock watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt    <= to_cnt_n;
      timeout_q <= timeout_n;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule
